// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: a small holding FIFO feeds a shifter that
// emits one bit per enabled clock, tagging the first and last bit of each word.
//
// state   | meaning
// S_IDLE  | line quiet (out=0), waiting for enable with a word queued
// S_SHIFT | a word is on the line, r_cnt indexes the bit currently shown
module piso_tx #(
  parameter int SIZE      = 8,
  parameter int DEPTH     = 2,
  parameter int MSB_FIRST = 1
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic [SIZE-1:0]            i_data_in,
  input  logic                       i_data_valid,
  output logic                       o_data_ready,
  input  logic                       i_enable,
  output logic                       o_out,
  output logic                       o_sof,
  output logic                       o_done,
  output logic                       o_busy,
  output logic [$clog2(DEPTH+1)-1:0] o_level
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(SIZE - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(SIZE - 2);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  logic [SIZE-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [LW-1:0]   r_level;
  state_t          r_state;
  logic [SIZE-1:0] r_shreg;
  logic [CW-1:0]   r_cnt;
  logic            r_out, r_sof, r_done;

  logic            w_push, w_pop, w_avail, w_load;
  logic [SIZE-1:0] w_head;
  logic            w_first_bit, w_next_bit;
  logic [SIZE-1:0] w_first_rest, w_next_rest;
  state_t          w_nx_state;
  logic [SIZE-1:0] w_nx_shreg;
  logic [CW-1:0]   w_nx_cnt;
  logic            w_nx_out, w_nx_sof, w_nx_done;

  assign o_data_ready = (r_level != LVL_FULL);
  assign w_push       = i_data_valid & o_data_ready;
  assign w_avail      = (r_level != '0);
  assign w_head       = r_mem[r_rptr];

  // Bits not yet shown stay left- or right-aligned so the next bit is always at one end.
  always_comb begin
    if (MSB_FIRST != 0) begin
      w_first_bit  = w_head[SIZE-1];
      w_first_rest = w_head << 1;
      w_next_bit   = r_shreg[SIZE-1];
      w_next_rest  = r_shreg << 1;
    end else begin
      w_first_bit  = w_head[0];
      w_first_rest = w_head >> 1;
      w_next_bit   = r_shreg[0];
      w_next_rest  = r_shreg >> 1;
    end
  end

  always_comb begin
    w_nx_state = r_state;
    w_nx_shreg = r_shreg;
    w_nx_cnt   = r_cnt;
    w_nx_out   = r_out;
    w_nx_sof   = r_sof;
    w_nx_done  = r_done;
    w_load     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_enable && w_avail) begin
          w_load = 1'b1;
        end else begin
          w_nx_out  = 1'b0;
          w_nx_sof  = 1'b0;
          w_nx_done = 1'b0;
        end
      end
      S_SHIFT: begin
        if (i_enable) begin
          if (r_cnt == CNT_LAST) begin
            if (w_avail) begin
              w_load = 1'b1;
            end else begin
              w_nx_state = S_IDLE;
              w_nx_out   = 1'b0;
              w_nx_sof   = 1'b0;
              w_nx_done  = 1'b0;
            end
          end else begin
            w_nx_out   = w_next_bit;
            w_nx_shreg = w_next_rest;
            w_nx_cnt   = r_cnt + CW'(1);
            w_nx_sof   = 1'b0;
            w_nx_done  = (r_cnt == CNT_PEN);
          end
        end
      end
      default: w_nx_state = S_IDLE;
    endcase
    if (w_load) begin
      w_nx_state = S_SHIFT;
      w_nx_out   = w_first_bit;
      w_nx_shreg = w_first_rest;
      w_nx_cnt   = '0;
      w_nx_sof   = 1'b1;
      w_nx_done  = 1'b0;
    end
  end

  assign w_pop = w_load;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_sof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nx_state;
      r_shreg <= w_nx_shreg;
      r_cnt   <= w_nx_cnt;
      r_out   <= w_nx_out;
      r_sof   <= w_nx_sof;
      r_done  <= w_nx_done;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by pointers and level.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign o_out   = r_out;
  assign o_sof   = r_sof;
  assign o_done  = r_done;
  assign o_busy  = (r_state == S_SHIFT);
  assign o_level = r_level;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances, expected bit tags are
// queued at word acceptance and retired by per-instance line monitors.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_val, a_en, a_rdy, a_out, a_sof, a_done, a_busy;
  logic [7:0] a_din;
  logic [1:0] a_lvl;
  logic       b_reset, b_val, b_en, b_rdy, b_out, b_sof, b_done, b_busy;
  logic [7:0] b_din;
  logic [1:0] b_lvl;

  piso_tx #(.SIZE(8), .DEPTH(2), .MSB_FIRST(1)) u_msb (
    .i_clk(clk), .i_reset(a_reset), .i_data_in(a_din), .i_data_valid(a_val),
    .o_data_ready(a_rdy), .i_enable(a_en), .o_out(a_out), .o_sof(a_sof),
    .o_done(a_done), .o_busy(a_busy), .o_level(a_lvl));

  piso_tx #(.SIZE(8), .DEPTH(2), .MSB_FIRST(0)) u_lsb (
    .i_clk(clk), .i_reset(b_reset), .i_data_in(b_din), .i_data_valid(b_val),
    .o_data_ready(b_rdy), .i_enable(b_en), .o_out(b_out), .o_sof(b_sof),
    .o_done(b_done), .o_busy(b_busy), .o_level(b_lvl));

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int nbits_a = 0;
  int nbits_b = 0;
  int fall_cyc_a = -1;
  int max_lvl_a = 0;
  logic prev_busy_a = 1'b0;
  logic [2:0] exp_a[$];
  logic [2:0] exp_b[$];
  int sof_cyc_a[$];
  int done_cyc_a[$];

  logic ena_s, rsta_s, enb_s, rstb_s;
  logic [2:0] ea, eb;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // {out, sof, done} for every bit of a word, in line order
  task automatic expect_word(input bit sel, input logic [7:0] w);
    logic b;
    for (int i = 0; i < 8; i++) begin
      b = sel ? w[i] : w[7-i];
      if (sel) exp_b.push_back({b, i == 0, i == 7});
      else     exp_a.push_back({b, i == 0, i == 7});
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    ena_s  = a_en;
    rsta_s = a_reset;
    #1;
    if (!rsta_s) begin
      if (int'(a_lvl) > max_lvl_a) max_lvl_a = int'(a_lvl);
      if (ena_s && a_busy) begin
        nbits_a++;
        if (a_sof)  sof_cyc_a.push_back(cyc);
        if (a_done) done_cyc_a.push_back(cyc);
        if (exp_a.size() == 0) begin
          chk("a_unexpected_bit", 32'({a_out, a_sof, a_done}), 32'hdead);
        end else begin
          ea = exp_a.pop_front();
          chk("a_bit", 32'({a_out, a_sof, a_done}), 32'(ea));
        end
      end else if (ena_s) begin
        chk("a_idle_line", 32'({a_out, a_sof, a_done}), 32'd0);
      end
      if (prev_busy_a && !a_busy) fall_cyc_a = cyc;
    end
    prev_busy_a = a_busy;
  end

  always @(posedge clk) begin
    enb_s  = b_en;
    rstb_s = b_reset;
    #1;
    if (!rstb_s) begin
      if (enb_s && b_busy) begin
        nbits_b++;
        if (exp_b.size() == 0) begin
          chk("b_unexpected_bit", 32'({b_out, b_sof, b_done}), 32'hdead);
        end else begin
          eb = exp_b.pop_front();
          chk("b_bit", 32'({b_out, b_sof, b_done}), 32'(eb));
        end
      end else if (enb_s) begin
        chk("b_idle_line", 32'({b_out, b_sof, b_done}), 32'd0);
      end
    end
  end

  task automatic send(input bit sel, input logic [7:0] w);
    int t;
    t = 0;
    @(negedge clk);
    if (sel) begin b_din = w; b_val = 1'b1; end
    else     begin a_din = w; a_val = 1'b1; end
    while (((sel ? b_rdy : a_rdy) == 1'b0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_ready_timeout", 32'(t >= 100), 32'd0);
    expect_word(sel, w);
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (sel) begin b_val = 1'b0; b_din = ~w; end
    else     begin a_val = 1'b0; a_din = ~w; end
  endtask

  task automatic drain(input bit sel);
    int t;
    t = 0;
    @(negedge clk);
    while (((sel ? exp_b.size() : exp_a.size()) != 0 || (sel ? b_busy : a_busy)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("drain_timeout", 32'(t >= 300), 32'd0);
    chk("pending_bits", 32'(sel ? exp_b.size() : exp_a.size()), 32'd0);
  endtask

  task automatic wait_bits(input bit sel, input int target);
    int t;
    t = 0;
    while ((sel ? nbits_b : nbits_a) < target && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("wait_bits_timeout", 32'(t >= 100), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n0;
    logic [3:0] snap;
    a_reset = 1'b1; b_reset = 1'b1;
    a_val = 1'b0; b_val = 1'b0;
    a_din = 8'h00; b_din = 8'h00;
    a_en = 1'b1; b_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out",   32'(a_out),  32'd0);
    chk("rst_sof",   32'(a_sof),  32'd0);
    chk("rst_done",  32'(a_done), 32'd0);
    chk("rst_busy",  32'(a_busy), 32'd0);
    chk("rst_level", 32'(a_lvl),  32'd0);
    chk("rst_ready", 32'(a_rdy),  32'd1);
    chk("rst_b_ready", 32'(b_rdy), 32'd1);
    a_reset = 1'b0; b_reset = 1'b0;
    @(negedge clk);

    // single word, latency and tag positions
    sof_cyc_a.delete(); done_cyc_a.delete();
    send(0, 8'hA5);
    drain(0);
    chk("t1_sof_count",  32'(sof_cyc_a.size()),  32'd1);
    chk("t1_done_count", 32'(done_cyc_a.size()), 32'd1);
    if (sof_cyc_a.size() > 0)  chk("t1_sof_edge",  32'(sof_cyc_a[0]),  32'(acc_cyc + 1));
    if (done_cyc_a.size() > 0) chk("t1_done_edge", 32'(done_cyc_a[0]), 32'(acc_cyc + 8));
    chk("t1_busy_fall_edge", 32'(fall_cyc_a), 32'(acc_cyc + 9));

    // back-to-back words without a gap bit
    sof_cyc_a.delete(); done_cyc_a.delete(); max_lvl_a = 0;
    send(0, 8'hF0);
    send(0, 8'h0F);
    drain(0);
    chk("t2_sof_count", 32'(sof_cyc_a.size()), 32'd2);
    if (sof_cyc_a.size() > 1 && done_cyc_a.size() > 1) begin
      chk("t2_no_gap",   32'(sof_cyc_a[1]),  32'(done_cyc_a[0] + 1));
      chk("t2_word2_len", 32'(done_cyc_a[1]), 32'(done_cyc_a[0] + 8));
    end
    chk("t2_level_peak", 32'(max_lvl_a), 32'd1);

    // stall mid-word
    n0 = nbits_a;
    send(0, 8'h81);
    wait_bits(0, n0 + 2);
    a_en = 1'b0;
    snap = {a_out, a_sof, a_done, a_busy};
    chk("t3_stall_entry", 32'(snap), 32'b0001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_hold", 32'({a_out, a_sof, a_done, a_busy}), 32'(snap));
    end
    a_en = 1'b1;
    drain(0);

    // full FIFO backpressure, drain order
    a_en = 1'b0;
    @(negedge clk);
    a_din = 8'h12; a_val = 1'b1;
    chk("t4_ready_w1", 32'(a_rdy), 32'd1);
    expect_word(0, 8'h12);
    @(negedge clk);
    a_din = 8'h34;
    chk("t4_ready_w2", 32'(a_rdy), 32'd1);
    expect_word(0, 8'h34);
    @(negedge clk);
    a_din = 8'hC7;
    chk("t4_full_ready", 32'(a_rdy), 32'd0);
    chk("t4_full_level", 32'(a_lvl), 32'd2);
    @(negedge clk);
    chk("t4_hold_ready", 32'(a_rdy), 32'd0);
    chk("t4_hold_level", 32'(a_lvl), 32'd2);
    a_en = 1'b1;
    @(negedge clk);
    chk("t4_ready_after_pop", 32'(a_rdy), 32'd1);
    chk("t4_level_after_pop", 32'(a_lvl), 32'd1);
    expect_word(0, 8'hC7);
    @(posedge clk);
    #1;
    a_val = 1'b0; a_din = 8'h00;
    drain(0);

    // reset mid-word with one word queued
    n0 = nbits_a;
    send(0, 8'h3C);
    send(0, 8'h99);
    wait_bits(0, n0 + 4);
    chk("t5_queued_level", 32'(a_lvl), 32'd1);
    a_reset = 1'b1;
    @(negedge clk);
    a_reset = 1'b0;
    exp_a.delete();
    chk("t5_out",   32'(a_out),  32'd0);
    chk("t5_sof",   32'(a_sof),  32'd0);
    chk("t5_done",  32'(a_done), 32'd0);
    chk("t5_busy",  32'(a_busy), 32'd0);
    chk("t5_level", 32'(a_lvl),  32'd0);
    chk("t5_ready", 32'(a_rdy),  32'd1);
    repeat (12) @(negedge clk);
    chk("t5_quiet_busy", 32'(a_busy), 32'd0);
    send(0, 8'h55);
    drain(0);

    // LSB-first, push coinciding with pop at level 1
    n0 = nbits_b;
    send(1, 8'h01);
    send(1, 8'h80);
    wait_bits(1, n0 + 8);
    chk("t6_level_before", 32'(b_lvl), 32'd1);
    b_din = 8'h6B; b_val = 1'b1;
    chk("t6_ready", 32'(b_rdy), 32'd1);
    expect_word(1, 8'h6B);
    @(posedge clk);
    #1;
    b_val = 1'b0; b_din = 8'h00;
    @(negedge clk);
    chk("t6_level_push_pop", 32'(b_lvl), 32'd1);
    drain(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
Parallel-in serial-out transmitter. It is the sending end of the serial bit stream consumed by the shift-register receivers in this codebase. Parallel words enter through a valid/ready handshake into a small holding FIFO. Each word is then shifted out one bit per enabled clock, with first-bit and last-bit tags and busy/done status so the downstream receiver can frame words.

Parameters:
SIZE, 8, word width in bits; legal range 2..64.
DEPTH, 2, holding FIFO entries; power of two, 2..16.
MSB_FIRST, 1, 1 = transmit bit SIZE-1 first; 0 = transmit bit 0 first.

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high reset.
data_in  input  SIZE  parallel word to transmit.
data_valid  input  1  data_in is valid.
data_ready  output  1  FIFO can accept a word; a word transfers on a clock edge where data_valid and data_ready are both high.
enable  input  1  bit-rate strobe; the shifter advances only on clock edges where enable is high.
out  output  1  serial data bit (registered).
sof  output  1  high while out carries bit 1 of a word.
done  output  1  high while out carries the last bit of a word.
busy  output  1  high while a word is on the line.
level  output  $clog2(DEPTH+1)  number of words held in the FIFO, excluding the word being shifted.

Behaviour:
- Reset (synchronous, active-high, one clock):
  - out=0, sof=0, done=0, busy=0, level=0, data_ready=1.
  - FIFO is emptied and the shifter returns to IDLE.
  - Reset in the middle of a word abandons that word and all queued words. No partial bits follow.
- FIFO:
  - data_ready = (level != DEPTH), combinational from registered state. There is no pass-through.
  - A push happens on valid&ready. A pop is issued by the shifter.
  - Push and pop on the same edge: level is unchanged and both operations take effect.
  - Read and write pointers wrap modulo DEPTH.
  - A push is never allowed when full, because ready is low. A pop is never issued when empty.
- Shifter states:
  - IDLE (busy=0) and SHIFT (busy=1), plus bit_count in the range 0..SIZE-1.
- IDLE, on an edge with enable=1 and level>0:
  - Pop the head word. The first bit goes onto out, the remaining bits go into the shift register.
  - sof<=1. done<=0. bit_count<=0. busy<=1. Move to SHIFT.
- IDLE, on an edge with enable=0 or level=0:
  - out<=0, sof<=0, done<=0.
- SHIFT, on an edge with enable=1:
  - If bit_count<SIZE-2: present the next bit, bit_count++, sof<=0.
  - If bit_count==SIZE-2: present the last bit, done<=1, bit_count++.
  - If bit_count==SIZE-1 (last bit already on the line):
    - With level>0, pop and present the first bit of the next word. sof<=1, done<=0, stay in SHIFT. The result is back-to-back words with no gap bit.
    - With level=0, go to IDLE: out<=0, busy<=0, done<=0.
- SHIFT, on an edge with enable=0:
  - Every register holds. out, sof, done and busy are stable during a stall.
  - sof and done are bit tags, not single-clock pulses.
- Latency: a word accepted at edge N can appear on out at the earliest after edge N+1, given enable=1 at N+1 and the shifter idle or finishing its last bit.
- Bit order:
  - MSB_FIRST=1: bits go out in the order SIZE-1 down to 0.
  - MSB_FIRST=0: bits go out in the order 0 up to SIZE-1.
- data_in is sampled only on the push edge. Later changes to data_in do not affect the stored word.

Test Plan:
1. SIZE=8, MSB_FIRST=1, enable=1 constantly, push 0xA5 at edge 0.
   - out over edges 1..8 = 1,0,1,0,0,1,0,1.
   - sof high only after edge 1, done high only after edge 8, busy high after edges 1..8.
   - After edge 9: busy=0, out=0.
2. Push 0xF0 then 0x0F on consecutive cycles, enable=1.
   - 16 contiguous bits 11110000 00001111, with sof at bits 1 and 9 and done at bits 8 and 16.
   - busy never drops between the two words. level peaks at 1.
3. Push 0x81, then hold enable=0 for 3 cycles after bit 2 is shown.
   - out, sof, done and busy are frozen for those 3 cycles.
   - The bit sequence resumes unchanged: 1,0,0,0,0,0,0,1.
4. DEPTH=2, enable=0, assert data_valid with 3 distinct words.
   - data_ready drops after 2 pushes and level=2. The third word is held by the source.
   - Raising enable drains the words in order. Ready returns after the first pop.
   - The third word transmits third.
5. Assert reset at bit 4 of 0x3C while 1 word is queued.
   - After that edge: out=0, busy=0, sof=0, done=0, level=0, data_ready=1.
   - No further bits appear. A new push of 0x55 then transmits cleanly.
6. MSB_FIRST=0, push 0x01.
   - out = 1,0,0,0,0,0,0,0.
   - Simultaneously push while popping with level=1: level stays 1.
